// File: rtl/hstate_follower.sv
// hstate_follower: receive-side tracker for the tagged fusion pixel stream.
// Counts accepted pixels per image, checks image-index tags, and stalls at set end.
//
// Ports:
//   hclk, hres_n       clock, asynchronous active-low reset
//   in_valid, in_state upstream beat valid and its image-index tag
//   in_ready           high when a beat can be accepted (low while awaiting ack)
//   pix_cnt            pixels accepted so far in the current image
//   exp_state          expected image index
//   img_done           one-cycle pulse after the last pixel of an image
//   set_done, set_ack  full image set received / downstream acknowledge
//   state_err, err_clr sticky tag-mismatch flag and its clear
module hstate_follower #(
    parameter int HIM_LEN           = 520,
    parameter int HIM_WID           = 520,
    parameter int LOG2_NO_OF_IMAGES = 4,
    parameter int CNT_W             = 19
) (
    input  logic                         hclk,
    input  logic                         hres_n,
    input  logic                         in_valid,
    input  logic [LOG2_NO_OF_IMAGES-1:0] in_state,
    output logic                         in_ready,
    output logic [CNT_W-1:0]             pix_cnt,
    output logic [LOG2_NO_OF_IMAGES-1:0] exp_state,
    output logic                         img_done,
    output logic                         set_done,
    input  logic                         set_ack,
    output logic                         state_err,
    input  logic                         err_clr
);

    localparam int S = LOG2_NO_OF_IMAGES;

    // Pixel count per image computed in 64 bits so the product never truncates.
    localparam logic [63:0]      NPIX     = 64'(HIM_LEN) * 64'(HIM_WID);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 64'd1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
    localparam logic [S-1:0]     S_ONE    = S'(1);

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_ACK = 1'b1
    } fsm_t;

    fsm_t             state;
    fsm_t             state_nx;
    logic [CNT_W-1:0] pix_nx;
    logic [S-1:0]     exp_nx;
    logic             img_nx;
    logic             set_nx;
    logic             err_nx;
    logic             accept;
    logic             last_pix;
    logic             tag_bad;

    assign in_ready = (state == RUN);
    assign accept   = in_valid & in_ready;
    assign last_pix = (pix_cnt == LAST_PIX);
    assign tag_bad  = (in_state != exp_state);

    always_ff @(posedge hclk or negedge hres_n) begin
        if (!hres_n) begin
            state     <= RUN;
            pix_cnt   <= '0;
            exp_state <= '0;
            img_done  <= 1'b0;
            set_done  <= 1'b0;
            state_err <= 1'b0;
        end else begin
            state     <= state_nx;
            pix_cnt   <= pix_nx;
            exp_state <= exp_nx;
            img_done  <= img_nx;
            set_done  <= set_nx;
            state_err <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pix_nx   = pix_cnt;
        exp_nx   = exp_state;
        img_nx   = 1'b0;
        set_nx   = set_done;
        unique case (state)
            RUN: begin
                if (accept) begin
                    if (last_pix) begin
                        pix_nx = '0;
                        img_nx = 1'b1;
                        exp_nx = exp_state + S_ONE;
                        // Last image of the set: stall until acknowledged.
                        if (&exp_state) begin
                            set_nx   = 1'b1;
                            state_nx = WAIT_ACK;
                        end
                    end else begin
                        pix_nx = pix_cnt + C_ONE;
                    end
                end
            end
            WAIT_ACK: begin
                if (set_ack) begin
                    set_nx   = 1'b0;
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // A fresh mismatch takes priority over a clear in the same cycle.
    always_comb begin
        err_nx = state_err;
        if (accept && tag_bad) begin
            err_nx = 1'b1;
        end else if (err_clr) begin
            err_nx = 1'b0;
        end
    end

endmodule

// File: tb/tb_hstate_follower.sv
// tb_hstate_follower: scoreboard bench for hstate_follower (4x4 images, 4-image sets).
// Driver pushes per-cycle expectations; a monitor pops and compares on negedge.
module tb_hstate_follower;

    localparam int L  = 4;
    localparam int W  = 4;
    localparam int S  = 2;
    localparam int CW = 5;
    localparam int NP = L * W;
    localparam int NI = 1 << S;

    logic          hclk = 1'b0;
    logic          hres_n = 1'b1;
    logic          in_valid = 1'b0;
    logic [S-1:0]  in_state = '0;
    logic          in_ready;
    logic [CW-1:0] pix_cnt;
    logic [S-1:0]  exp_state;
    logic          img_done;
    logic          set_done;
    logic          set_ack = 1'b0;
    logic          state_err;
    logic          err_clr = 1'b0;

    hstate_follower #(
        .HIM_LEN(L), .HIM_WID(W), .LOG2_NO_OF_IMAGES(S), .CNT_W(CW)
    ) dut (
        .hclk(hclk), .hres_n(hres_n), .in_valid(in_valid),
        .in_state(in_state), .in_ready(in_ready), .pix_cnt(pix_cnt),
        .exp_state(exp_state), .img_done(img_done), .set_done(set_done),
        .set_ack(set_ack), .state_err(state_err), .err_clr(err_clr)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        int pix;
        int exs;
        int img;
        int sd;
        int err;
        int rdy;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference: beats accepted since reset / last ack, plus wait and error flags.
    int   m_acc  = 0;
    bit   m_wait = 0;
    bit   m_err  = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: reset values checked asynchronously, otherwise pop per cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge hclk or negedge hres_n);
            if (!hres_n) begin
                #1;
                chk("rst_pix", int'(pix_cnt), 0);
                chk("rst_exp", int'(exp_state), 0);
                chk("rst_img", int'(img_done), 0);
                chk("rst_set", int'(set_done), 0);
                chk("rst_err", int'(state_err), 0);
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pix_cnt", int'(pix_cnt), e.pix);
                chk("exp_state", int'(exp_state), e.exs);
                chk("img_done", int'(img_done), e.img);
                chk("set_done", int'(set_done), e.sd);
                chk("state_err", int'(state_err), e.err);
                chk("in_ready", int'(in_ready), e.rdy);
            end
        end
    end

    function automatic logic [S-1:0] cur_exp();
        return S'((m_acc / NP) % NI);
    endfunction

    // Drive one cycle, predict the post-edge outputs, push after the edge.
    task automatic step(input bit v, input logic [S-1:0] tag,
                        input bit ack, input bit clr);
        exp_t e;
        bit   acc;
        bit   mis;
        in_valid = v;
        in_state = tag;
        set_ack  = ack;
        err_clr  = clr;
        acc = v && !m_wait;
        mis = acc && (tag != cur_exp());
        if (acc) m_acc++;
        e.img = (acc && (m_acc % NP == 0)) ? 1 : 0;
        if (m_wait && ack) begin
            m_wait = 0;
            m_acc  = 0;
        end else if (acc && m_acc == NP * NI) begin
            m_wait = 1;
        end
        if (mis) m_err = 1;
        else if (clr) m_err = 0;
        e.pix = m_acc % NP;
        e.exs = (m_acc / NP) % NI;
        e.sd  = m_wait ? 1 : 0;
        e.rdy = m_wait ? 0 : 1;
        e.err = m_err ? 1 : 0;
        @(posedge hclk);
        sb.push_back(e);
        #2;
    endtask

    task automatic beat(input bit v);
        step(v, cur_exp(), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge hclk);
        #2 hres_n = 1'b0;
        in_valid = 1'b0;
        set_ack  = 1'b0;
        err_clr  = 1'b0;
        m_acc  = 0;
        m_wait = 0;
        m_err  = 0;
        #10;
        @(negedge hclk);
        #2 hres_n = 1'b1;
        @(posedge hclk);
        #2;
    endtask

    initial begin : driver
        #3 hres_n = 1'b0;
        #10;
        @(negedge hclk);
        #2 hres_n = 1'b1;
        @(posedge hclk);
        #2;

        // Full set with correct tags: pulses after 16/32/48/64, then stall.
        for (int i = 0; i < NP * NI; i++) beat(1'b1);

        // Held beats while waiting do nothing; ack releases the stall.
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        beat(1'b1);

        // Bad tag on the third beat of the image; count still advances.
        beat(1'b1);
        step(1'b1, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) beat(1'b1);
        for (int i = 0; i < 3; i++) beat(1'b0);

        // Clear racing a fresh mismatch loses; a lone clear wins.
        step(1'b1, 2'd3, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0);

        // Gappy stream across image and set boundaries.
        for (int i = 0; i < 160; i++) begin
            if (m_wait)
                step($urandom_range(0, 1) == 1, cur_exp(),
                     $urandom_range(0, 2) == 0, 1'b0);
            else
                beat($urandom_range(0, 1) == 1);
        end

        // Async reset mid-image at pix 7 / image 2.
        do_reset();
        for (int i = 0; i < 2 * NP + 7; i++) beat(1'b1);
        do_reset();
        beat(1'b1);
        beat(1'b0);

        repeat (3) @(posedge hclk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hstate_follower.md
Name: hstate_follower

Overview:
- Receive-side counterpart of the pipeline state generator: consumes the tagged pixel stream at the tail of the fusion pipeline.
- Counts accepted pixels per image and keeps its own expected image index.
- Checks each beat's image-index tag against the expected index, pulses on every image boundary, and holds the stream at the end of each full image set until downstream acknowledges.

Parameters:
- HIM_LEN, 520, image length in pixels
- HIM_WID, 520, image width in pixels
- LOG2_NO_OF_IMAGES, 4, width of the image-index tag; a set holds 2**LOG2_NO_OF_IMAGES images
- CNT_W, 19, pixel counter width; must satisfy 2**CNT_W >= HIM_LEN*HIM_WID

Ports:
- hclk  in  1  clock
- hres_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream beat valid
- in_state  in  LOG2_NO_OF_IMAGES  image-index tag carried with the beat
- in_ready  out  1  follower can accept a beat
- pix_cnt  out  CNT_W  pixels accepted so far in the current image
- exp_state  out  LOG2_NO_OF_IMAGES  expected image index
- img_done  out  1  one-cycle pulse when the last pixel of an image is accepted
- set_done  out  1  level; a full image set has been received and awaits ack
- set_ack  in  1  downstream acknowledge of set_done
- state_err  out  1  sticky tag-mismatch flag
- err_clr  in  1  clears state_err

Behaviour:
- Interface: one clock, hclk; reset hres_n is asynchronous and active-low.
- Reset (hres_n=0, immediate, no clock needed):
  - FSM=RUN, pix_cnt=0, exp_state=0
  - img_done=0, set_done=0, state_err=0
  - in_ready=1 once reset is released; a reset mid-image discards the partial count.
- Beat acceptance: a beat is accepted when in_valid & in_ready are high at a rising hclk edge. No other event advances the counters.
- FSM state RUN:
  - in_ready=1.
  - On an accepted beat with pix_cnt != HIM_LEN*HIM_WID-1: pix_cnt <= pix_cnt+1.
  - On an accepted beat with pix_cnt == HIM_LEN*HIM_WID-1 (last pixel):
    - pix_cnt <= 0, img_done=1 for the next cycle only, exp_state <= exp_state+1 (modulo 2**LOG2_NO_OF_IMAGES).
    - If exp_state was all-ones, also set_done <= 1 and FSM <= WAIT_ACK.
- FSM state WAIT_ACK:
  - in_ready=0 (combinational from state); pix_cnt=0 and exp_state=0 are held.
  - On set_ack=1: set_done <= 0, FSM <= RUN; in_ready=1 from the next cycle.
  - set_ack in RUN is ignored.
  - set_ack in the same cycle that set_done is being set is ignored; the ack is only sampled in WAIT_ACK.
- Tag check:
  - On every accepted beat, in_state != exp_state sets state_err <= 1.
  - The counter still advances and exp_state is not resynchronised to the tag.
- err_clr: clears state_err on the next edge. If err_clr and a new mismatch occur in the same cycle, set wins (state_err=1).
- Latency:
  - pix_cnt and exp_state update 1 cycle after acceptance.
  - img_done, set_done and state_err are registered, asserting the cycle after the causing beat.
- Arithmetic: the comparison uses the constant HIM_LEN*HIM_WID-1 evaluated at elaboration, wide enough to avoid truncation; pix_cnt never exceeds HIM_LEN*HIM_WID-1.
- in_valid with in_ready=0 has no effect; upstream must hold the beat (no drop, no count).

Test Plan:
- Reset then a continuous valid stream with correct tags, HIM_LEN=HIM_WID=4, LOG2=2 -> img_done pulses after beats 16, 32, 48, 64; exp_state steps 1,2,3,0; set_done=1 and in_ready=0 after beat 64.
- In WAIT_ACK, hold in_valid=1 for 5 cycles, then set_ack=1 -> no count change while waiting; set_done=0 and in_ready=1 the cycle after the ack; the next beat makes pix_cnt=1.
- Inject in_state=2 while exp_state=0 at beat 3 -> state_err=1 the next cycle; the img_done pulse still follows beat 16; state_err stays 1 until err_clr.
- Assert err_clr together with a mismatching accepted beat -> state_err remains 1; err_clr alone on the next cycle -> state_err=0.
- Toggle in_valid randomly at 50% -> img_done pulses only after exactly 16 accepted beats per image, independent of gaps.
- Drop hres_n mid-image at pix_cnt=7, exp_state=2 -> all outputs return to 0 asynchronously before the next edge; after release the first beat gives pix_cnt=1, exp_state=0.
